// File: rtl/bt_pkg.sv
// Shared types, default sizes and the WRAP length check for the burst SRAM engine.
package bt_pkg;

    localparam int BT_ADDR_WIDTH = 8;
    localparam int BT_DATA_WIDTH = 32;
    localparam int BT_MAX_BURST  = 16;
    localparam int BT_STRIDE_W   = 4;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_INCR  = 2'd1,
        MODE_WRAP  = 2'd2
    } burst_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // len is beats minus one; a WRAP burst needs a power-of-two beat count of at least two
    function automatic logic wrap_len_ok(input logic [31:0] len);
        logic [31:0] beats;
        beats = len + 32'd1;
        return (len != 32'd0) && ((len & beats) == 32'd0);
    endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Per-burst address sequencer: latches the command, then steps one beat per advance.
module burst_addr_gen
    import bt_pkg::*;
#(
    parameter int ADDR_WIDTH = BT_ADDR_WIDTH,
    parameter int LEN_W      = 4,
    parameter int STRIDE_W   = BT_STRIDE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  advance_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_WIDTH-1:0] start_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [STRIDE_W-1:0]   stride_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] start_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH-1:0] mask_s;
    logic [1:0]            mode_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      cnt_q;
    logic [STRIDE_W-1:0]   stride_q;

    assign mask_s = ADDR_WIDTH'(len_q);

    // Next beat address; WRAP keeps the aligned upper bits and cycles the low bits
    always_comb begin
        addr_d = addr_q;
        case (mode_q)
            MODE_INCR: addr_d = addr_q + ADDR_WIDTH'(stride_q);
            MODE_WRAP: addr_d = (start_q & ~mask_s) |
                                ((addr_q + ADDR_WIDTH'(1'b1)) & mask_s);
            default:   addr_d = addr_q;
        endcase
    end

    // Command latch and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q  <= {ADDR_WIDTH{1'b0}};
            addr_q   <= {ADDR_WIDTH{1'b0}};
            mode_q   <= 2'd0;
            len_q    <= {LEN_W{1'b0}};
            cnt_q    <= {LEN_W{1'b0}};
            stride_q <= {STRIDE_W{1'b0}};
        end else if (load_i) begin
            start_q  <= start_i;
            addr_q   <= start_i;
            mode_q   <= mode_i;
            len_q    <= len_i;
            cnt_q    <= {LEN_W{1'b0}};
            stride_q <= stride_i;
        end else if (advance_i) begin
            addr_q   <= addr_d;
            cnt_q    <= cnt_q + LEN_W'(1'b1);
        end else begin
            cnt_q    <= cnt_q;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == len_q);

endmodule

// File: rtl/burst_sram_engine.sv
// Burst engine in front of a single-port SRAM: one command at a time, write beats in,
// read beats out through a 2-entry buffer with full backpressure.
module burst_sram_engine
    import bt_pkg::*;
#(
    parameter  int ADDR_WIDTH = BT_ADDR_WIDTH,
    parameter  int DATA_WIDTH = BT_DATA_WIDTH,
    parameter  int MAX_BURST  = BT_MAX_BURST,
    parameter  int STRIDE_W   = BT_STRIDE_W,
    localparam int LEN_W      = $clog2(MAX_BURST)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [1:0]            cmd_mode,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [STRIDE_W-1:0]   cmd_stride,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_last,
    output logic                  busy,
    output logic                  cmd_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_e                state_q;
    state_e                state_d;
    logic                  rdy_q;
    logic                  err_q;
    logic                  err_d;
    logic                  ag_load_s;
    logic                  ag_adv_s;
    logic                  ag_last_s;
    logic [ADDR_WIDTH-1:0] ag_addr_s;
    logic                  mem_we_s;
    logic                  rd_issue_s;
    logic                  cmd_fire_s;
    logic                  cmd_bad_s;
    logic                  room_s;
    logic                  push_s;
    logic                  pop_s;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_last_q;
    logic                  inflight_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [1:0]            fifo_last_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;

    burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_W      (LEN_W),
        .STRIDE_W   (STRIDE_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ag_load_s),
        .advance_i (ag_adv_s),
        .mode_i    (cmd_mode),
        .start_i   (cmd_addr),
        .len_i     (cmd_len),
        .stride_i  (cmd_stride),
        .addr_o    (ag_addr_s),
        .last_o    (ag_last_s)
    );

    assign cmd_fire_s = cmd_valid && rdy_q;
    assign cmd_bad_s  = (cmd_mode == 2'd3) ||
                        ((cmd_mode == MODE_WRAP) && !wrap_len_ok(32'(cmd_len)));

    // A beat popped this cycle frees its slot, which keeps back-to-back reads flowing
    assign push_s = inflight_q;
    assign pop_s  = (count_q != 2'd0) && rdata_ready;
    assign room_s = (({1'b0, count_q} + {2'b00, inflight_q}) - {2'b00, pop_s}) < 3'd2;

    // Next-state and per-cycle strobes
    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        ag_load_s  = 1'b0;
        ag_adv_s   = 1'b0;
        mem_we_s   = 1'b0;
        rd_issue_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire_s && cmd_bad_s) begin
                    err_d = 1'b1;
                end else if (cmd_fire_s) begin
                    ag_load_s = 1'b1;
                    state_d   = cmd_write ? ST_WRITE : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wdata_valid) begin
                    mem_we_s = 1'b1;
                    ag_adv_s = 1'b1;
                    state_d  = ag_last_s ? ST_IDLE : ST_WRITE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (room_s) begin
                    rd_issue_s = 1'b1;
                    ag_adv_s   = 1'b1;
                    state_d    = ag_last_s ? ST_DRAIN : ST_READ;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if ((count_q == 2'd0) && !inflight_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset aborts any burst in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            inflight_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= (state_d == ST_IDLE);
            err_q      <= err_d;
            inflight_q <= rd_issue_s;
            rd_last_q  <= ag_last_s;
        end
    end

    // Storage array: contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[ag_addr_s] <= wdata;
        end
        if (rd_issue_s) begin
            rd_data_q <= mem_q[ag_addr_s];
        end
    end

    // Two-entry read output buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_data_q[0] <= {DATA_WIDTH{1'b0}};
            fifo_data_q[1] <= {DATA_WIDTH{1'b0}};
            fifo_last_q    <= 2'b00;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_data_q[wr_ptr_q] <= rd_data_q;
                fifo_last_q[wr_ptr_q] <= rd_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= (count_q + {1'b0, push_s}) - {1'b0, pop_s};
        end
    end

    assign cmd_ready   = rdy_q;
    assign cmd_err     = err_q;
    assign busy        = (state_q != ST_IDLE);
    assign wdata_ready = (state_q == ST_WRITE);
    assign rdata_valid = (count_q != 2'd0);
    assign rdata       = rdata_valid ? fifo_data_q[rd_ptr_q] : {DATA_WIDTH{1'b0}};
    assign rdata_last  = rdata_valid && fifo_last_q[rd_ptr_q];

endmodule
